// File: rtl/bus_address_unit.sv
// rtl/bus_address_unit.sv - segmented bus address unit running a T1..T4 memory cycle
//
// Purpose: forms a 20-bit physical address from segment:offset and runs one
// memory bus cycle (T1 address latch, T2 strobe, T3 wait/ready, T4 finish)
// with a bounded number of wait states.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, rw           cycle request (sampled in IDLE), 0 = read, 1 = write
//   segment, offset     address inputs, sampled with start
//   wdata               write data, sampled with start
//   mem_ready           memory ready, sampled in T3 only
//   mem_rdata           memory read data, captured on a ready read in T3
//   addr                physical address, held from T1 and kept in IDLE
//   ale                 address latch enable (T1)
//   mem_rd, mem_wr      read / write strobes (T2, T3)
//   mem_wdata           write data while mem_wr, otherwise 0
//   rdata               last captured read data
//   busy                cycle in progress (T1..T4)
//   done, err           one-cycle completion pulse and its timeout flag

module bus_address_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [15:0] segment,
  input  logic [15:0] offset,
  input  logic [15:0] wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [19:0] addr,
  output logic        ale,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state;
  logic        rw_q;
  logic [15:0] wdata_q;
  logic [7:0]  wait_cnt;
  logic [19:0] phys_addr;

  // 20-bit sum: the carry out of bit 19 falls off, giving the real-mode wrap.
  assign phys_addr = {segment, 4'h0} + {4'h0, offset};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      wdata_q   <= 16'h0;
      wait_cnt  <= 8'h0;
      addr      <= 20'h0;
      ale       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= 16'h0;
      rdata     <= 16'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr     <= phys_addr;
            rw_q     <= rw;
            wdata_q  <= wdata;
            wait_cnt <= 8'h0;
            ale      <= 1'b1;
            busy     <= 1'b1;
            state    <= T1;
          end
        end
        T1: begin
          // Outputs are registered, so the T2 strobes are set on the way out of T1.
          ale       <= 1'b0;
          mem_rd    <= ~rw_q;
          mem_wr    <= rw_q;
          mem_wdata <= rw_q ? wdata_q : 16'h0;
          state     <= T2;
        end
        T2: begin
          state <= T3;
        end
        T3: begin
          if (mem_ready || (wait_cnt == MAX_WAIT_C)) begin
            if (mem_ready && !rw_q) begin
              rdata <= mem_rdata;
            end
            err       <= ~mem_ready;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= 16'h0;
            done      <= 1'b1;
            state     <= T4;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        T4: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_address_unit.sv
// tb/tb_bus_address_unit.sv - scoreboard bench for bus_address_unit
module tb_bus_address_unit;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] segment = 16'h0;
  logic [15:0] offset = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [19:0] addr;
  logic        ale, mem_rd, mem_wr, busy, done, err;
  logic [15:0] mem_wdata, rdata;

  bus_address_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .segment(segment),
    .offset(offset), .wdata(wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .addr(addr), .ale(ale), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        err;
    int          lat;
    int          stb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks the cycle from busy rising, checks strobe rules every
  // cycle and compares against the scoreboard head on each done pulse.
  int   cyc = 0, stb = 0, alec = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (busy && !busy_q) begin
      cyc = 1; stb = 0; alec = 0;
    end else if (busy) begin
      cyc++;
    end
    if (ale) alec++;
    if (mem_rd || mem_wr) stb++;
    if (busy) begin
      check("rd_wr_exclusive", {31'h0, mem_rd & mem_wr}, 32'h0);
      if (!mem_wr) check("wdata_zero", {16'h0, mem_wdata}, 32'h0);
      else if (sb.size() > 0) check("mem_wdata", {16'h0, mem_wdata}, {16'h0, sb[0].wd});
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("addr", {12'h0, addr}, {12'h0, e.addr});
        check("rdata", {16'h0, rdata}, {16'h0, e.rd});
        check("err", {31'h0, err}, {31'h0, e.err});
        check("latency", cyc, e.lat);
        check("strobe_cycles", stb, e.stb);
        check("ale_cycles", alec, 1);
      end
    end
    busy_q = busy;
  end

  // mode 0: normal, 1: start pulsed in T2 and T4, 2: reset in first T3 cycle.
  // Entered and left on a falling edge.
  task automatic do_cycle(input logic rw_i, input logic [15:0] seg, input logic [15:0] off,
                          input logic [15:0] wd, input logic [15:0] bus_rd, input int waits,
                          input int mode, input logic [19:0] e_addr, input logic [15:0] e_rd,
                          input logic e_err);
    exp_t e;
    int   n_t3;
    if (mode != 2) begin
      e.addr = e_addr; e.wd = rw_i ? wd : 16'h0; e.rd = e_rd; e.err = e_err;
      e.lat = 4 + (e_err ? MAX_WAIT : waits);
      e.stb = 2 + (e_err ? MAX_WAIT : waits);
      sb.push_back(e);
      pushed++;
    end
    rst = 1'b0; start = 1'b1; rw = rw_i; segment = seg; offset = off; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b1; mem_rdata = bus_rd;   // ready outside T3 must be ignored
    @(negedge clk);                                       // T1
    @(negedge clk);                                       // T2
    if (mode == 1) begin start = 1'b1; segment = 16'h2000; end
    n_t3 = e_err ? MAX_WAIT + 1 : waits + 1;
    for (int i = 0; i < n_t3; i++) begin
      @(negedge clk);                                     // T3 cycle i
      start = 1'b0; segment = seg;
      mem_ready = (!e_err && i == waits);
      if (mode == 2) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_outputs", {12'h0, addr, ale, mem_rd, mem_wr, done, err, 7'h0},
              {12'h0, 20'h0, 5'h0, 7'h0});
        check("abort_data", {mem_wdata, rdata}, 32'h0);
        mem_ready = 1'b0;
        return;
      end
    end
    @(negedge clk);                                       // T4
    mem_ready = 1'b0;
    if (mode == 1) start = 1'b1;
    @(negedge clk);                                       // IDLE
    start = 1'b0;
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("idle_addr_hold", {12'h0, addr}, {12'h0, e_addr});
  endtask

  initial begin
    // Reset overrides start and mem_ready on the same edge.
    rst = 1'b1; start = 1'b1; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_outputs", {12'h0, addr, ale, mem_rd, mem_wr, done, err, 7'h0}, 32'h0);
    check("reset_data", {mem_wdata, rdata}, 32'h0);
    start = 1'b0; mem_ready = 1'b0;

    do_cycle(1'b0, 16'h1234, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, 20'h12350, 16'hBEEF, 1'b0);
    do_cycle(1'b0, 16'hFFFF, 16'h0010, 16'h0000, 16'h1111, 1, 0, 20'h00000, 16'h1111, 1'b0);
    do_cycle(1'b1, 16'hF000, 16'hFFFF, 16'h5A5A, 16'h3C3C, 0, 0, 20'hFFFFF, 16'h1111, 1'b0);
    do_cycle(1'b1, 16'h1000, 16'h0234, 16'hA5A5, 16'h3C3C, 2, 0, 20'h10234, 16'h1111, 1'b0);
    do_cycle(1'b0, 16'h0ABC, 16'h0004, 16'h0000, 16'hDEAD, 0, 0, 20'h0ABC4, 16'h1111, 1'b1);
    do_cycle(1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h0F0F, 0, 1, 20'h88000, 16'h0F0F, 1'b0);
    do_cycle(1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h9999, 0, 2, 20'h40000, 16'h9999, 1'b0);
    do_cycle(1'b0, 16'h0001, 16'h0001, 16'h0000, 16'h7777, 3, 0, 20'h00011, 16'h7777, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", done_cnt, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_address_unit.md
BUS_ADDRESS_UNIT -- requirements
Module: bus_address_unit

Interface
REQ-001 The block SHALL have one parameter: MAX_WAIT, default 15, the maximum number of T3 wait cycles before the cycle is aborted (range 1..255).
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 start  input  1  Request a bus cycle; sampled only in IDLE.
REQ-005 rw  input  1  Cycle type: 0 read, 1 write; sampled with start.
REQ-006 segment  input  16  Segment value from the segment register file; sampled with start.
REQ-007 offset  input  16  Effective offset; sampled with start.
REQ-008 wdata  input  16  Write data; sampled with start.
REQ-009 mem_ready  input  1  Memory ready; sampled in T3.
REQ-010 mem_rdata  input  16  Memory read data; captured when mem_ready=1 in T3.
REQ-011 addr  output  20  Physical address.
REQ-012 ale  output  1  Address latch enable.
REQ-013 mem_rd / mem_wr  output  1 each  Read / write strobes.
REQ-014 mem_wdata  output  16  Write data to memory.
REQ-015 rdata  output  16  Captured read data.
REQ-016 busy  output  1  Cycle in progress.
REQ-017 done  output  1  One-cycle completion pulse.
REQ-018 err  output  1  Timeout flag; valid while done=1.

Function
REQ-019 The state machine SHALL have the states IDLE, T1, T2, T3 and T4.
REQ-020 In IDLE with start=1, the block SHALL latch rw, wdata and addr = ({segment,4'h0} + {4'h0,offset}) mod 2^20 (carry out of bit 19 discarded), and SHALL go to T1.
REQ-021 T1 SHALL assert ale=1 and SHALL go to T2 unconditionally.
REQ-022 T2 SHALL assert mem_rd (rw=0) or mem_wr (rw=1), SHALL drive mem_wdata with the latched wdata on writes, and SHALL go to T3.
REQ-023 T3 SHALL hold the strobe and mem_wdata. If mem_ready=1, it SHALL go to T4, capturing mem_rdata into rdata on reads. Otherwise it SHALL increment the wait counter.
REQ-024 When the wait counter equals MAX_WAIT and mem_ready=0, the block SHALL go to T4 with err=1, and rdata SHALL be left unchanged.
REQ-025 T4 SHALL deassert the strobes, SHALL pulse done=1 for exactly one cycle, and SHALL return to IDLE.
REQ-026 The wait counter SHALL clear on entry to T1.
REQ-027 err SHALL be 1 only during T4 of a timed-out cycle.
REQ-028 busy SHALL be 1 in T1 through T4 and 0 in IDLE.
REQ-029 With zero wait states, done SHALL occur 4 cycles after the start-sample edge (T1, T2, T3, T4); each wait cycle SHALL add 1.
REQ-030 addr SHALL remain stable from T1 through T4 and SHALL hold its last value in IDLE.
REQ-031 start SHALL be ignored in T1 through T4, and no request SHALL be queued.
REQ-032 start asserted during T4 SHALL be ignored; the next request is sampled in IDLE.
REQ-033 mem_rd and mem_wr SHALL never be asserted simultaneously.
REQ-034 mem_ready SHALL be ignored outside T3.
REQ-035 mem_wdata SHALL be 0 whenever mem_wr=0.

Reset
REQ-036 When rst=1 on a clock edge, the block SHALL enter IDLE and SHALL set addr=0, ale=0, mem_rd=0, mem_wr=0, mem_wdata=0, rdata=0, busy=0, done=0, err=0 and the wait counter to 0.
REQ-037 rst SHALL override start and mem_ready on the same edge.
REQ-038 rst asserted mid-cycle (any of T1..T4) SHALL abort the cycle with no done pulse.
REQ-039 The block SHALL accept a new start on the first edge after rst deasserts.

Verification
REQ-040 Read, segment=0x1234, offset=0x0010, mem_ready=1, mem_rdata=0xBEEF -> addr=0x12350, ale in T1, mem_rd in T2/T3, done 4 cycles after start, rdata=0xBEEF, err=0.
REQ-041 Wrap-around, segment=0xFFFF, offset=0x0010 -> addr=0x00000; segment=0xF000, offset=0xFFFF -> addr=0xFFFFF.
REQ-042 Write, wdata=0xA5A5, mem_ready low for 2 T3 cycles then high -> mem_wr held 4 cycles (T2 plus 3 T3), mem_wdata=0xA5A5, done 6 cycles after start, err=0.
REQ-043 Timeout, MAX_WAIT=15, mem_ready held 0 -> T4 after 15 wait cycles, done=1 with err=1, rdata unchanged.
REQ-044 start pulsed in T2 with a different segment -> ignored; addr unchanged; exactly one done pulse.
REQ-045 rst asserted in T3 -> next cycle IDLE, all outputs 0, no done; a new start then completes normally.
